// File: rtl/gardner_iq_agc.sv
// gardner_iq_agc
//   Adaptive-shift I/Q pre-processor that sits between the matched filter and
//   the Gardner timing loop. It tracks the joint I/Q peak magnitude over a
//   window of 2^WIN_LOG2 accepted samples, then picks an arithmetic right
//   shift that keeps the scaled peak below 2^TARGET_MSB. Both channels are
//   shifted and saturated to OUT_WIDTH. A manual mode forces a fixed shift.
//
//   Optional build macro: GARDNER_IQ_AGC_ROUND_EN
//     defined   -> round-half-up shift: (x + 2^(s-1)) >>> s for s > 0
//     undefined -> floor (truncating) shift
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   I_in_tdata/tvalid            signed I sample and valid
//   Q_in_tdata/tvalid            signed Q sample and valid
//   manual_en, manual_shift      force the shift (window logic frozen)
//   I_out_tdata/tvalid           scaled I, 2-cycle latency
//   Q_out_tdata/tvalid           scaled Q, 2-cycle latency
//   shift_out                    shift applied to newly accepted samples
//   shift_upd                    one-cycle pulse after each window end
module gardner_iq_agc #(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int WIN_LOG2   = 8,
    parameter int MAX_SHIFT  = 7,
    parameter int INIT_SHIFT = 2,
    parameter int TARGET_MSB = 13,
    localparam int SW = $clog2(MAX_SHIFT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  I_in_tdata,
    input  logic                 I_in_tvalid,
    input  logic [IN_WIDTH-1:0]  Q_in_tdata,
    input  logic                 Q_in_tvalid,
    input  logic                 manual_en,
    input  logic [SW-1:0]        manual_shift,
    output logic [OUT_WIDTH-1:0] I_out_tdata,
    output logic                 I_out_tvalid,
    output logic [OUT_WIDTH-1:0] Q_out_tdata,
    output logic                 Q_out_tvalid,
    output logic [SW-1:0]        shift_out,
    output logic                 shift_upd
);

    typedef enum logic [1:0] {ACQ, TRACK, MAN} state_t;

    // Saturation bounds expressed in the IN_WIDTH+1 working width.
    localparam logic signed [IN_WIDTH:0] OMAX =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] OMIN =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [SW-1:0] SMAX = SW'(MAX_SHIFT);

    state_t                state_q, state_d;
    logic [SW-1:0]         shift_q, shift_d, man_sh, d_shift;
    logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
    logic [IN_WIDTH:0]     peak_q, peak_d, mag_i, mag_q, m, peak_nxt;
    logic                  acc, win_end, upd_q, upd_d;
    int                    p_idx, d_raw;

    // Pipeline: vld_pipe[0] = S1 accept, vld_pipe[1] = output valid.
    logic [1:0]            vld_pipe;
    logic [IN_WIDTH-1:0]   s1_i, s1_q;
    logic [SW-1:0]         s1_sh;

    // |x| in one extra bit so the most negative input is exact.
    function automatic logic [IN_WIDTH:0] mag(input logic [IN_WIDTH-1:0] x);
        logic signed [IN_WIDTH:0] e;
        e = {x[IN_WIDTH-1], x};
        return e[IN_WIDTH] ? $unsigned(-e) : $unsigned(e);
    endfunction

    function automatic logic [OUT_WIDTH-1:0] scale(input logic [IN_WIDTH-1:0] x,
                                                   input logic [SW-1:0] s);
        logic signed [IN_WIDTH:0] e;
        e = {x[IN_WIDTH-1], x};
`ifdef GARDNER_IQ_AGC_ROUND_EN
        if (s != '0)
            e = e + $signed((IN_WIDTH+1)'(1) << (s - 1'b1));
`endif
        e = e >>> s;
        if (e > OMAX)
            return OMAX[OUT_WIDTH-1:0];
        else if (e < OMIN)
            return OMIN[OUT_WIDTH-1:0];
        return e[OUT_WIDTH-1:0];
    endfunction

    assign acc     = I_in_tvalid & Q_in_tvalid;
    assign win_end = (cnt_q == {WIN_LOG2{1'b1}});
    assign mag_i   = mag(I_in_tdata);
    assign mag_q   = mag(Q_in_tdata);
    assign man_sh  = (manual_shift > SMAX) ? SMAX : manual_shift;

    // Peak including the current sample, and the shift it asks for.
    always_comb begin
        m        = (mag_i > mag_q) ? mag_i : mag_q;
        peak_nxt = (m > peak_q) ? m : peak_q;
        p_idx    = -1;
        for (int k = 0; k <= IN_WIDTH; k++)
            if (peak_nxt[k]) p_idx = k;
        d_raw = p_idx - TARGET_MSB + 1;
        if (d_raw < 0)
            d_shift = '0;
        else if (d_raw > MAX_SHIFT)
            d_shift = SMAX;
        else
            d_shift = SW'(d_raw);
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        peak_d  = peak_q;
        upd_d   = 1'b0;
        if (manual_en) begin
            // Manual wins over a coincident window end.
            state_d = MAN;
            shift_d = man_sh;
            cnt_d   = '0;
            peak_d  = '0;
        end else begin
            if (state_q == MAN) state_d = TRACK;
            if (acc) begin
                if (win_end) begin
                    cnt_d   = '0;
                    peak_d  = '0;
                    upd_d   = 1'b1;
                    state_d = TRACK;
                    if (state_q == ACQ)
                        shift_d = d_shift;
                    else if (d_shift > shift_q)
                        shift_d = shift_q + 1'b1;
                    else if (d_shift < shift_q)
                        shift_d = shift_q - 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    peak_d = peak_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACQ;
            shift_q <= SW'(INIT_SHIFT);
            cnt_q   <= '0;
            peak_q  <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            peak_q  <= peak_d;
            upd_q   <= upd_d;
        end
    end

    // S1 captures the shift alongside the data so a window-end update never
    // touches the sample that closed the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe    <= '0;
            s1_i        <= '0;
            s1_q        <= '0;
            s1_sh       <= '0;
            I_out_tdata <= '0;
            Q_out_tdata <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[0], acc};
            s1_i        <= I_in_tdata;
            s1_q        <= Q_in_tdata;
            s1_sh       <= shift_q;
            I_out_tdata <= vld_pipe[0] ? scale(s1_i, s1_sh) : '0;
            Q_out_tdata <= vld_pipe[0] ? scale(s1_q, s1_sh) : '0;
        end
    end

    assign I_out_tvalid = vld_pipe[1];
    assign Q_out_tvalid = vld_pipe[1];
    assign shift_out    = shift_q;
    assign shift_upd    = upd_q;

endmodule
